// File: rtl/array_21_rw_ctrl_if.sv
// Request/response and RW0 SRAM port bundle for array_21_rw_ctrl.
// The master side is the cache pipeline plus the array wrapper; the slave side is the controller.
interface array_21_rw_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 256,
  parameter int MASK_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic              RW0_clk;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [ADDR_W-1:0] RW0_addr;
  logic [DATA_W-1:0] RW0_wdata;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready, RW0_rdata,
    input  req_ready, resp_valid, resp_rdata, init_done,
    input  RW0_clk, RW0_en, RW0_wmode, RW0_addr, RW0_wdata, RW0_wmask
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready, RW0_rdata,
    output req_ready, resp_valid, resp_rdata, init_done,
    output RW0_clk, RW0_en, RW0_wmode, RW0_addr, RW0_wdata, RW0_wmask
  );
endinterface

// File: rtl/array_21_rw_ctrl.sv
// Requester-side RW0 SRAM controller with in-order, credit-limited read response FIFO.
// Optional zero-fill sweep after reset: define ARRAY21_RW_CTRL_INIT_EN.

module array_21_rw_ctrl_chk (
  input logic i_clock,
  input logic i_reset,
  input logic i_push,
  input logic i_pop,
  input logic i_full
);
  a_no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
    !(i_push && i_full && !i_pop));
endmodule

module array_21_rw_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 256,
  parameter int RESP_DEPTH = 4
) (
  input logic                clock,
  input logic                reset,
  array_21_rw_ctrl_if.slave  bus
);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_sweep;
  logic              w_sweep_last;
  logic              w_req_ready;
  logic              w_fire;
  logic              w_rw0_en;
  logic              w_rw0_wmode;
  logic [ADDR_W-1:0] w_rw0_addr;
  logic [DATA_W-1:0] w_rw0_wdata;
  logic [bus.MASK_W-1:0] w_rw0_wmask;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [CNT_W:0]    w_credits;

  logic              r_inflight;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_mem [RESP_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef ARRAY21_RW_CTRL_INIT_EN
  localparam state_t ST_RESET = ST_INIT;
  logic [ADDR_W-1:0] r_sweep;

  // Sweep address holds at the last entry so it never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sweep <= '0;
    end else if (r_state == ST_INIT && !w_sweep_last) begin
      r_sweep <= r_sweep + ADDR_W'(1);
    end else begin
      r_sweep <= r_sweep;
    end
  end

  assign w_sweep      = r_sweep;
  assign w_sweep_last = (r_sweep == {ADDR_W{1'b1}});
`else
  localparam state_t ST_RESET = ST_RUN;
  assign w_sweep      = '0;
  assign w_sweep_last = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Credits count both queued and in-flight reads, so resp_ready never reaches req_ready.
  assign w_credits = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_fire    = bus.req_valid && w_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rw0_en    = 1'b0;
    w_rw0_wmode = 1'b0;
    w_rw0_addr  = bus.req_addr;
    w_rw0_wdata = bus.req_wdata;
    w_rw0_wmask = bus.req_wmask;
    case (r_state)
      ST_INIT: begin
        w_rw0_en    = 1'b1;
        w_rw0_wmode = 1'b1;
        w_rw0_addr  = w_sweep;
        w_rw0_wdata = '0;
        w_rw0_wmask = '1;
        if (w_sweep_last) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN: begin
        w_req_ready = (w_credits < (CNT_W + 1)'(RESP_DEPTH));
        w_rw0_en    = bus.req_valid && w_req_ready;
        w_rw0_wmode = bus.req_valid && w_req_ready && bus.req_write;
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  assign w_push = r_inflight;
  assign w_pop  = (r_count != '0) && bus.resp_ready;
  assign w_full = (r_count == CNT_W'(RESP_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= w_fire && !bus.req_write;
      r_wr_ptr   <= w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
      r_rd_ptr   <= w_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read data is captured the cycle after its read-enable.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.RW0_rdata;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = (r_count != '0);
  assign bus.resp_rdata = r_mem[r_rd_ptr];
  assign bus.init_done  = (r_state == ST_RUN);
  assign bus.RW0_clk    = clock;
  assign bus.RW0_en     = w_rw0_en;
  assign bus.RW0_wmode  = w_rw0_wmode;
  assign bus.RW0_addr   = w_rw0_addr;
  assign bus.RW0_wdata  = w_rw0_wdata;
  assign bus.RW0_wmask  = w_rw0_wmask;

  array_21_rw_ctrl_chk u_chk (
    .i_clock (clock),
    .i_reset (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_full  (w_full)
  );
endmodule

// File: tb/tb_array_21_rw_ctrl.sv
// Randomised self-checking bench for array_21_rw_ctrl: behavioural SRAM plus a
// transaction-level reference (shadow memory and expected-response queue).
module tb_array_21_rw_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;

  array_21_rw_ctrl_if #(.ADDR_W(12), .DATA_W(256), .MASK_W(16)) bus ();

  array_21_rw_ctrl #(.ADDR_W(12), .DATA_W(256), .RESP_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [255:0] data;
    int           t;
  } resp_t;

  logic [255:0] sram [4096];
  logic [255:0] ref_mem [4096];
  logic [255:0] sram_rdata;
  resp_t        rq[$];
  int           t;
  int           n_checks = 0;
  int           n_err    = 0;
  logic         obs_ready;

  function automatic logic [255:0] pat(input int i);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'(i) * 32'h9E37_79B1 + 32'(k);
    return r;
  endfunction

  assign bus.RW0_rdata = sram_rdata;

  // Behavioural single-port SRAM with one-cycle read latency.
  initial begin
    sram_rdata = '0;
    for (int i = 0; i < 4096; i++) sram[i] = pat(i);
    forever begin
      @(posedge clock);
      if (bus.RW0_en) begin
        if (bus.RW0_wmode) begin
          for (int j = 0; j < 16; j++)
            if (bus.RW0_wmask[j]) sram[bus.RW0_addr][16*j +: 16] = bus.RW0_wdata[16*j +: 16];
        end else begin
          sram_rdata <= sram[bus.RW0_addr];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic cycle(input logic v, input logic w, input logic [11:0] a,
                       input logic [255:0] d, input logic [15:0] m, input logic rr);
    logic         exp_ready, fire, exp_valid, exp_done;
    logic [255:0] bm;
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_wmask  = m;
    bus.resp_ready = rr;
    @(negedge clock);
    chk("rw0_clk", bus.RW0_clk, 1'b0);
`ifdef ARRAY21_RW_CTRL_INIT_EN
    exp_done = (t >= 4096);
`else
    exp_done = 1'b1;
`endif
    chk("init_done", bus.init_done, exp_done);
`ifdef ARRAY21_RW_CTRL_INIT_EN
    if (t < 4096) begin
      chk("req_ready_init", bus.req_ready, 1'b0);
      chk("sweep_en", bus.RW0_en, 1'b1);
      chk("sweep_wmode", bus.RW0_wmode, 1'b1);
      chk("sweep_addr", bus.RW0_addr, 256'(t));
      chk("sweep_wdata", bus.RW0_wdata, 256'h0);
      chk("sweep_wmask", bus.RW0_wmask, 256'hFFFF);
      ref_mem[t] = '0;
    end else
`endif
    begin
      exp_ready = (rq.size() < 4);
      chk("req_ready", bus.req_ready, exp_ready);
      fire = v && exp_ready;
      chk("rw0_en", bus.RW0_en, fire);
      chk("rw0_wmode", bus.RW0_wmode, fire && w);
      if (fire) begin
        chk("rw0_addr", bus.RW0_addr, a);
        if (w) begin
          chk("rw0_wdata", bus.RW0_wdata, d);
          chk("rw0_wmask", bus.RW0_wmask, m);
          for (int j = 0; j < 16; j++) bm[16*j +: 16] = m[j] ? 16'hFFFF : 16'h0000;
          ref_mem[a] = (ref_mem[a] & ~bm) | (d & bm);
        end else begin
          rq.push_back('{ref_mem[a], t});
        end
      end
    end
    exp_valid = (rq.size() > 0) && (rq[0].t + 2 <= t);
    chk("resp_valid", bus.resp_valid, exp_valid);
    if (exp_valid) begin
      chk("resp_rdata", bus.resp_rdata, rq[0].data);
      if (rr) void'(rq.pop_front());
    end
    obs_ready = bus.req_ready;
    t++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 12'h000, 256'h0, 16'h0000, 1'b1);
  endtask

  task automatic apply_reset();
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    rq.delete();
    t = 0;
  endtask

  task automatic wait_init();
`ifdef ARRAY21_RW_CTRL_INIT_EN
    idle(4096);
`else
    idle(1);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           k;
    logic [255:0] rd;
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wmask = '0;   bus.resp_ready = 1'b0;
    t = 0;
    apply_reset();

`ifdef ARRAY21_RW_CTRL_INIT_EN
    idle(12'h400);
    apply_reset();
    idle(4096 + 2);
    cycle(1'b1, 1'b0, 12'h7FF, 256'h0, 16'h0000, 1'b1);
    idle(3);
`else
    idle(1);
    cycle(1'b1, 1'b0, 12'h010, 256'h0, 16'h0000, 1'b1);
    idle(3);
`endif

    // Single access, then partial-mask write.
    cycle(1'b1, 1'b1, 12'h123, {32{8'hA5}}, 16'hFFFF, 1'b1);
    cycle(1'b1, 1'b0, 12'h123, 256'h0, 16'h0000, 1'b1);
    idle(3);
    cycle(1'b1, 1'b1, 12'h055, {256{1'b1}}, 16'hFFFF, 1'b1);
    cycle(1'b1, 1'b1, 12'h055, 256'h0, 16'h0001, 1'b1);
    cycle(1'b1, 1'b0, 12'h055, 256'h0, 16'h0000, 1'b1);
    idle(3);

    // Backpressure: six reads against a stalled consumer.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 1'b0, 12'(12'h200 + k), 256'h0, 16'h0000, 1'b0);
      if (obs_ready) k++;
    end
    chk("bp_accepts", 256'(k), 256'd4);
    for (int c = 0; c < 30 && k < 6; c++) begin
      cycle(1'b1, 1'b0, 12'(12'h200 + k), 256'h0, 16'h0000, 1'b1);
      if (obs_ready) k++;
    end
    chk("bp_all_accepted", 256'(k), 256'd6);
    idle(6);

    // Reset with reads in flight discards them.
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 12'(12'h300 + c), 256'h0, 16'h0000, 1'b0);
    apply_reset();
    wait_init();
    idle(2);

    // Random traffic over a small address window to exercise read-after-write.
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < 8; j++) rd[32*j +: 32] = $urandom;
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            12'(12'h3F0 + $urandom_range(0, 15)), rd, 16'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
